// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port round-robin arbiter/sequencer in front of the shared
// 16-bit registered ALU. One operation is outstanding at a time:
// IDLE (accept) -> ISSUE (ALU samples issue registers) -> RESP (hold until consumed).
//
// Ports:
//   CLK, Reset (async, active-low)
//   ReqValid0/1, ReqReady0/1, ReqA0/1, ReqB0/1, ReqOp0/1   request channels
//   RespValid0/1, RespReady0/1, RespData, RespZero          response channels
//   AluFirst, AluSecond, AluOp (registered) / AluResult, AluZero   ALU link
//   Busy (not IDLE), OpCount (completed ops, wrapping)
module alu_arbiter (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        ReqValid0,
    input  logic        ReqValid1,
    output logic        ReqReady0,
    output logic        ReqReady1,
    input  logic [15:0] ReqA0,
    input  logic [15:0] ReqA1,
    input  logic [15:0] ReqB0,
    input  logic [15:0] ReqB1,
    input  logic [2:0]  ReqOp0,
    input  logic [2:0]  ReqOp1,
    output logic        RespValid0,
    output logic        RespValid1,
    input  logic        RespReady0,
    input  logic        RespReady1,
    output logic [15:0] RespData,
    output logic        RespZero,
    output logic [15:0] AluFirst,
    output logic [15:0] AluSecond,
    output logic [2:0]  AluOp,
    input  logic [15:0] AluResult,
    input  logic        AluZero,
    output logic        Busy,
    output logic [15:0] OpCount
);

    localparam int unsigned DW  = 16;
    localparam int unsigned OPW = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    first_q, first_d;
    logic [DW-1:0]    second_q, second_d;
    logic [OPW-1:0]   op_q, op_d;
    logic             owner_q, owner_d;
    logic             last_grant_q, last_grant_d;
    logic [DW-1:0]    op_count_q, op_count_d;

    logic             grant_c;
    logic             req_ready0_c, req_ready1_c;
    logic             resp_valid0_c, resp_valid1_c;
    logic             resp_done_c;

    // State and issue registers
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q      <= IDLE;
            first_q      <= '0;
            second_q     <= '0;
            op_q         <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            first_q      <= first_d;
            second_q     <= second_d;
            op_q         <= op_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            op_count_q   <= op_count_d;
        end
    end

    // Next-state, arbitration and handshake logic
    always_comb begin
        state_d       = state_q;
        first_d       = first_q;
        second_d      = second_q;
        op_d          = op_q;
        owner_d       = owner_q;
        last_grant_d  = last_grant_q;
        op_count_d    = op_count_q;
        req_ready0_c  = 1'b0;
        req_ready1_c  = 1'b0;
        resp_valid0_c = 1'b0;
        resp_valid1_c = 1'b0;
        resp_done_c   = 1'b0;

        // On a tie the port that did not win last time is granted
        if (ReqValid0 && ReqValid1) begin
            grant_c = ~last_grant_q;
        end else begin
            grant_c = ReqValid1;
        end

        case (state_q)
            IDLE: begin
                if (ReqValid0 || ReqValid1) begin
                    req_ready0_c = ~grant_c;
                    req_ready1_c = grant_c;
                    first_d      = grant_c ? ReqA1  : ReqA0;
                    second_d     = grant_c ? ReqB1  : ReqB0;
                    op_d         = grant_c ? ReqOp1 : ReqOp0;
                    owner_d      = grant_c;
                    last_grant_d = grant_c;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                state_d = RESP;
            end
            RESP: begin
                resp_valid0_c = ~owner_q;
                resp_valid1_c = owner_q;
                resp_done_c   = owner_q ? RespReady1 : RespReady0;
                if (resp_done_c) begin
                    // Zero opcode parks the ALU between operations
                    op_d       = '0;
                    op_count_d = op_count_q + DW'(1);
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ReqReady0  = req_ready0_c;
    assign ReqReady1  = req_ready1_c;
    assign RespValid0 = resp_valid0_c;
    assign RespValid1 = resp_valid1_c;
    assign RespData   = AluResult;
    assign RespZero   = AluZero;
    assign AluFirst   = first_q;
    assign AluSecond  = second_q;
    assign AluOp      = op_q;
    assign Busy       = (state_q != IDLE);
    assign OpCount    = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter with a small one-cycle registered ALU model.
module tb_alu_arbiter;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic        ReqValid0 = 1'b0, ReqValid1 = 1'b0;
    logic        ReqReady0, ReqReady1;
    logic [15:0] ReqA0 = '0, ReqA1 = '0, ReqB0 = '0, ReqB1 = '0;
    logic [2:0]  ReqOp0 = '0, ReqOp1 = '0;
    logic        RespValid0, RespValid1;
    logic        RespReady0 = 1'b0, RespReady1 = 1'b0;
    logic [15:0] RespData;
    logic        RespZero;
    logic [15:0] AluFirst, AluSecond;
    logic [2:0]  AluOp;
    logic [15:0] AluResult = '0;
    logic        AluZero = 1'b1;
    logic        Busy;
    logic [15:0] OpCount;

    int n_checks = 0;
    int n_fail   = 0;

    alu_arbiter dut (
        .CLK(CLK), .Reset(Reset),
        .ReqValid0(ReqValid0), .ReqValid1(ReqValid1),
        .ReqReady0(ReqReady0), .ReqReady1(ReqReady1),
        .ReqA0(ReqA0), .ReqA1(ReqA1), .ReqB0(ReqB0), .ReqB1(ReqB1),
        .ReqOp0(ReqOp0), .ReqOp1(ReqOp1),
        .RespValid0(RespValid0), .RespValid1(RespValid1),
        .RespReady0(RespReady0), .RespReady1(RespReady1),
        .RespData(RespData), .RespZero(RespZero),
        .AluFirst(AluFirst), .AluSecond(AluSecond), .AluOp(AluOp),
        .AluResult(AluResult), .AluZero(AluZero),
        .Busy(Busy), .OpCount(OpCount)
    );

    always #5 CLK = ~CLK;

    // Registered ALU stand-in: 0 and, 1 add, 2 sub, 3 or, 4 xor, 5 shl, 6 shr, 7 pass B
    always @(posedge CLK) begin
        logic [15:0] r;
        case (AluOp)
            3'd0: r = AluFirst & AluSecond;
            3'd1: r = AluFirst + AluSecond;
            3'd2: r = AluFirst - AluSecond;
            3'd3: r = AluFirst | AluSecond;
            3'd4: r = AluFirst ^ AluSecond;
            3'd5: r = AluFirst << AluSecond[3:0];
            3'd6: r = AluFirst >> AluSecond[3:0];
            default: r = AluSecond;
        endcase
        AluResult <= r;
        AluZero   <= (r == 16'd0);
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        // ---------------- reset state ----------------
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        Reset = 1'b1;
        #1;
        check("rst_busy", 16'(Busy), 16'd0);
        check("rst_aluop", 16'(AluOp), 16'd0);
        check("rst_alufirst", AluFirst, 16'd0);
        check("rst_alusecond", AluSecond, 16'd0);
        check("rst_opcount", OpCount, 16'd0);
        check("rst_rv0", 16'(RespValid0), 16'd0);
        check("rst_rv1", 16'(RespValid1), 16'd0);
        check("rst_rr0", 16'(ReqReady0), 16'd0);
        check("rst_respdata", RespData, 16'd0);
        check("rst_respzero", 16'(RespZero), 16'd1);

        // ---------------- single op, port 0: 5 + 3 ----------------
        @(negedge CLK);
        ReqValid0 = 1'b1; ReqA0 = 16'd5; ReqB0 = 16'd3; ReqOp0 = 3'd1; RespReady0 = 1'b1;
        #1;
        check("single_rr0", 16'(ReqReady0), 16'd1);
        check("single_rr1", 16'(ReqReady1), 16'd0);
        @(negedge CLK);
        ReqValid0 = 1'b0;
        #1;
        check("single_issue_busy", 16'(Busy), 16'd1);
        check("single_issue_rv0", 16'(RespValid0), 16'd0);
        check("single_alufirst", AluFirst, 16'd5);
        check("single_alusecond", AluSecond, 16'd3);
        check("single_aluop", 16'(AluOp), 16'd1);
        @(negedge CLK);
        #1;
        check("single_rv0", 16'(RespValid0), 16'd1);
        check("single_rv1", 16'(RespValid1), 16'd0);
        check("single_data", RespData, 16'd8);
        check("single_zero", 16'(RespZero), 16'd0);
        @(negedge CLK);
        #1;
        check("single_opcount", OpCount, 16'd1);
        check("single_quiesce_op", 16'(AluOp), 16'd0);
        check("single_idle_busy", 16'(Busy), 16'd0);

        // ---------------- contention from reset ----------------
        @(negedge CLK);
        Reset = 1'b0;
        ReqValid0 = 1'b1; ReqA0 = 16'd10; ReqB0 = 16'd10; ReqOp0 = 3'd2;
        ReqValid1 = 1'b1; ReqA1 = 16'd1;  ReqB1 = 16'd4;  ReqOp1 = 3'd5;
        RespReady0 = 1'b1; RespReady1 = 1'b1;
        @(negedge CLK);
        Reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            logic exp_port;
            exp_port = 1'(i % 2);
            #1;
            check($sformatf("cont%0d_rr0", i), 16'(ReqReady0), 16'(!exp_port));
            check($sformatf("cont%0d_rr1", i), 16'(ReqReady1), 16'(exp_port));
            @(negedge CLK);
            @(negedge CLK);
            #1;
            check($sformatf("cont%0d_rv0", i), 16'(RespValid0), 16'(!exp_port));
            check($sformatf("cont%0d_rv1", i), 16'(RespValid1), 16'(exp_port));
            check($sformatf("cont%0d_data", i), RespData, exp_port ? 16'd16 : 16'd0);
            check($sformatf("cont%0d_zero", i), 16'(RespZero), exp_port ? 16'd0 : 16'd1);
            @(negedge CLK);
        end
        #1;
        check("cont_opcount", OpCount, 16'd6);

        // ---------------- backpressure on port 1: 7 - 2 ----------------
        ReqValid0 = 1'b0;
        ReqValid1 = 1'b1; ReqA1 = 16'd7; ReqB1 = 16'd2; ReqOp1 = 3'd2;
        RespReady1 = 1'b0; RespReady0 = 1'b0;
        #1;
        check("bp_rr1", 16'(ReqReady1), 16'd1);
        @(negedge CLK);
        ReqValid1 = 1'b0;
        ReqValid0 = 1'b1; ReqA0 = 16'd1; ReqB0 = 16'd1; ReqOp0 = 3'd1;
        #1;
        check("bp_issue_rr0", 16'(ReqReady0), 16'd0);
        @(negedge CLK);
        for (int i = 0; i < 10; i++) begin
            RespReady0 = 1'(i % 2);
            #1;
            check($sformatf("bp%0d_rv1", i), 16'(RespValid1), 16'd1);
            check($sformatf("bp%0d_data", i), RespData, 16'd5);
            check($sformatf("bp%0d_rr0", i), 16'(ReqReady0), 16'd0);
            check($sformatf("bp%0d_rv0", i), 16'(RespValid0), 16'd0);
            @(negedge CLK);
        end
        RespReady0 = 1'b0;
        RespReady1 = 1'b1;
        #1;
        check("bp_final_rv1", 16'(RespValid1), 16'd1);
        check("bp_opcount_held", OpCount, 16'd6);
        @(negedge CLK);
        #1;
        check("bp_opcount", OpCount, 16'd7);
        check("bp_lone_rr0", 16'(ReqReady0), 16'd1);
        ReqValid0 = 1'b0;
        #1;
        check("bp_withdrawn_rr0", 16'(ReqReady0), 16'd0);

        // ---------------- OpCount wrap: 3 ^ 3 on port 1 ----------------
        @(negedge CLK);
        force dut.op_count_q = 16'hFFFF;
        @(negedge CLK);
        release dut.op_count_q;
        #1;
        check("wrap_preload", OpCount, 16'hFFFF);
        ReqValid1 = 1'b1; ReqA1 = 16'd3; ReqB1 = 16'd3; ReqOp1 = 3'd4;
        #1;
        check("wrap_rr1", 16'(ReqReady1), 16'd1);
        @(negedge CLK);
        ReqValid1 = 1'b0;
        @(negedge CLK);
        #1;
        check("wrap_rv1", 16'(RespValid1), 16'd1);
        check("wrap_data", RespData, 16'd0);
        check("wrap_zero", 16'(RespZero), 16'd1);
        @(negedge CLK);
        #1;
        check("wrap_opcount", OpCount, 16'h0000);

        // ---------------- reset during RESP: 100 + (-1) ----------------
        RespReady0 = 1'b0;
        ReqValid0 = 1'b1; ReqA0 = 16'd100; ReqB0 = 16'hFFFF; ReqOp0 = 3'd1;
        #1;
        check("rstmid_rr0", 16'(ReqReady0), 16'd1);
        @(negedge CLK);
        ReqValid0 = 1'b0;
        @(negedge CLK);
        #1;
        check("rstmid_rv0", 16'(RespValid0), 16'd1);
        check("rstmid_data", RespData, 16'd99);
        check("rstmid_aluop", 16'(AluOp), 16'd1);
        Reset = 1'b0;
        #1;
        check("rstmid_rv0_drop", 16'(RespValid0), 16'd0);
        check("rstmid_rv1_drop", 16'(RespValid1), 16'd0);
        check("rstmid_busy", 16'(Busy), 16'd0);
        check("rstmid_aluop_clr", 16'(AluOp), 16'd0);
        check("rstmid_opcount", OpCount, 16'd0);
        @(negedge CLK);
        Reset = 1'b1;
        @(negedge CLK);
        #1;
        check("post_rst_busy", 16'(Busy), 16'd0);
        check("post_rst_opcount", OpCount, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
